// File: rtl/pwmdt_pkg.sv
// ============================================================================
//  Module   : pwmdt_pkg
//  Brief    : Shared state encoding and defaults for the dead-time gate driver.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package pwmdt_pkg;

    localparam int PWMDT_DT_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_DEAD = 2'd1,
        ST_HI   = 2'd2,
        ST_LO   = 2'd3
    } pwmdt_state_e;

endpackage

`default_nettype wire

// File: rtl/deadtime_counter.sv
// ============================================================================
//  Module   : deadtime_counter
//  Brief    : Loadable down-counter with zero flag; saturates at zero.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module deadtime_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count_q;
    logic [WIDTH-1:0] w_count_d;

    assign o_zero = (r_count_q == '0);

    always_comb begin
        w_count_d = r_count_q;
        if (i_clr) begin
            w_count_d = '0;
        end else if (i_load) begin
            w_count_d = i_load_val;
        end else if (i_dec && !o_zero) begin
            w_count_d = r_count_q - C_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pwm_deadtime.sv
// ============================================================================
//  Module   : pwm_deadtime
//  Brief    : Complementary half-bridge drive with programmable dead time.
//             Optional latched trip input enabled by PWMDT_FAULT_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pwm_deadtime
    import pwmdt_pkg::*;
#(
    parameter int dt_width_p = PWMDT_DT_WIDTH_DEFAULT
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  enable_in,
    input  logic                  pwm_in,
    input  logic [dt_width_p-1:0] dead_cycles_in,
    output logic                  pwm_hi_out,
    output logic                  pwm_lo_out,
    output logic                  dead_out
`ifdef PWMDT_FAULT_EN
    ,
    input  logic                  fault_in,
    output logic                  fault_out
`endif
);

    localparam logic [dt_width_p-1:0] C_ONE = {{(dt_width_p-1){1'b0}}, 1'b1};

    pwmdt_state_e          r_state_q;
    pwmdt_state_e          w_state_d;
    logic                  w_fault_active;
    logic                  w_cnt_zero;
    logic                  w_load;
    logic                  w_dec;
    logic                  w_clr;
    logic [dt_width_p-1:0] w_load_val;

`ifdef PWMDT_FAULT_EN
    logic r_fault_q;
    logic w_fault_d;

    assign w_fault_active = fault_in | r_fault_q;
    assign fault_out      = r_fault_q;

    // Fault wins over a simultaneous disable; a clean disabled edge clears it.
    always_comb begin
        w_fault_d = r_fault_q;
        if (fault_in) begin
            w_fault_d = 1'b1;
        end else if (!enable_in) begin
            w_fault_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_fault_q <= 1'b0;
        end else begin
            r_fault_q <= w_fault_d;
        end
    end
`else
    assign w_fault_active = 1'b0;
`endif

    // A programmed dead time of 0 behaves as 1, so the load value is D-1 clamped.
    assign w_load_val = (dead_cycles_in == '0) ? '0 : (dead_cycles_in - C_ONE);

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            ST_OFF:  if (enable_in)  w_state_d = ST_DEAD;
            ST_HI:   if (!pwm_in)    w_state_d = ST_DEAD;
            ST_LO:   if (pwm_in)     w_state_d = ST_DEAD;
            ST_DEAD: if (w_cnt_zero) w_state_d = pwm_in ? ST_HI : ST_LO;
            default: w_state_d = ST_OFF;
        endcase
        if (!enable_in || w_fault_active) begin
            w_state_d = ST_OFF;
        end
    end

    assign w_load = (w_state_d == ST_DEAD) && (r_state_q != ST_DEAD);
    assign w_dec  = (w_state_d == ST_DEAD) && (r_state_q == ST_DEAD);
    assign w_clr  = (w_state_d == ST_OFF);

    deadtime_counter #(
        .WIDTH (dt_width_p)
    ) u_counter (
        .clk        (clk_in),
        .rst        (rst_in),
        .i_clr      (w_clr),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state_q  <= ST_OFF;
            pwm_hi_out <= 1'b0;
            pwm_lo_out <= 1'b0;
            dead_out   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            pwm_hi_out <= (w_state_d == ST_HI);
            pwm_lo_out <= (w_state_d == ST_LO);
            dead_out   <= (w_state_d == ST_DEAD);
        end
    end

endmodule

`default_nettype wire
